// File: rtl/phit_injector_if.sv
// phit_injector_if: descriptor and payload-word valid/ready handshakes into the phit injector.
// Ports: i_pkt_valid/o_pkt_ready with i_pkt_route, i_pkt_len; i_word_valid/o_word_ready with i_word.
interface phit_injector_if #(
    parameter int ROUTE_W   = 6,
    parameter int PAYLOAD_W = 10,
    parameter int LEN_W     = 5
);
    logic                 i_pkt_valid;
    logic                 o_pkt_ready;
    logic [ROUTE_W-1:0]   i_pkt_route;
    logic [LEN_W-1:0]     i_pkt_len;
    logic                 i_word_valid;
    logic                 o_word_ready;
    logic [PAYLOAD_W-1:0] i_word;

    modport master (
        output i_pkt_valid, i_pkt_route, i_pkt_len, i_word_valid, i_word,
        input  o_pkt_ready, o_word_ready
    );

    modport slave (
        input  i_pkt_valid, i_pkt_route, i_pkt_len, i_word_valid, i_word,
        output o_pkt_ready, o_word_ready
    );
endinterface

// File: rtl/phit_injector.sv
// phit_injector: store-and-forward source that emits contiguous head/body/tail phit trains.
// Ports: i_clk, i_rst (async active-low), bus (descriptor/word handshakes),
//        o_phit (registered phit or idle), o_busy, o_err (illegal-length pulse), o_pkt_sent (packet count).
module phit_injector #(
    parameter int PHIT_W    = 18,
    parameter int PAYLOAD_W = 10,
    parameter int ROUTE_W   = 6,
    parameter int MAX_LEN   = 16,
    parameter int GAP       = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    phit_injector_if.slave    bus,
    output logic [PHIT_W-1:0] o_phit,
    output logic              o_busy,
    output logic              o_err,
    output logic [15:0]       o_pkt_sent
);
    localparam int LW = 5;
    localparam int AW = $clog2(MAX_LEN);
    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    state_t               state_q;
    logic [ROUTE_W-1:0]   route_q;
    logic [LW-1:0]        len_q;
    logic [LW-1:0]        idx_q;
    logic [GW-1:0]        gap_q;
    logic                 stg_vld_q;
    logic [1:0]           stg_kind_q;
    logic [PAYLOAD_W-1:0] stg_word_q;
    logic [PHIT_W-1:0]    phit_q;
    logic                 err_q;
    logic [15:0]          sent_q;
    logic [PAYLOAD_W-1:0] mem_q [MAX_LEN];

    logic                 len_ok;
    logic [1:0]           kind_d;
    logic [PHIT_W-1:0]    phit_d;

    assign len_ok = bus.i_pkt_len >= LW'(2) && bus.i_pkt_len <= LW'(MAX_LEN);
    assign kind_d = (idx_q == '0) ? 2'b10 : (idx_q == len_q - LW'(1)) ? 2'b01 : 2'b11;
    // Route only travels in the head phit; body and tail carry zeros there.
    assign phit_d = stg_vld_q ? {stg_kind_q, (stg_kind_q == 2'b10) ? route_q : ROUTE_W'(0), stg_word_q} : '0;

    assign bus.o_pkt_ready  = state_q == S_IDLE;
    assign bus.o_word_ready = state_q == S_LOAD;
    assign o_busy           = state_q != S_IDLE;
    assign o_phit           = phit_q;
    assign o_err            = err_q;
    assign o_pkt_sent       = sent_q;

    always_ff @(posedge i_clk)
        if (state_q == S_LOAD && bus.i_word_valid)
            mem_q[idx_q[AW-1:0]] <= bus.i_word;

    // SEND stages buffer word idx_q one cycle ahead of o_phit, so the head lands
    // two edges after the last word; idx_q == len_q is the edge the tail is registered.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= S_IDLE;
            route_q    <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            gap_q      <= '0;
            stg_vld_q  <= 1'b0;
            stg_kind_q <= '0;
            stg_word_q <= '0;
            phit_q     <= '0;
            err_q      <= 1'b0;
            sent_q     <= '0;
        end else begin
            err_q     <= 1'b0;
            stg_vld_q <= 1'b0;
            phit_q    <= phit_d;
            case (state_q)
                S_IDLE:
                    if (bus.i_pkt_valid) begin
                        route_q <= bus.i_pkt_route;
                        len_q   <= bus.i_pkt_len;
                        idx_q   <= '0;
                        if (len_ok) state_q <= S_LOAD;
                        else err_q <= 1'b1;
                    end
                S_LOAD:
                    if (bus.i_word_valid) begin
                        idx_q <= idx_q + LW'(1);
                        if (idx_q == len_q - LW'(1)) begin
                            idx_q   <= '0;
                            state_q <= S_SEND;
                        end
                    end
                S_SEND:
                    if (idx_q != len_q) begin
                        stg_vld_q  <= 1'b1;
                        stg_kind_q <= kind_d;
                        stg_word_q <= mem_q[idx_q[AW-1:0]];
                        idx_q      <= idx_q + LW'(1);
                    end else begin
                        sent_q  <= sent_q + 16'd1;
                        gap_q   <= GW'(GAP);
                        state_q <= (GAP == 0) ? S_IDLE : S_GAP;
                    end
                S_GAP: begin
                    gap_q <= gap_q - GW'(1);
                    if (gap_q == GW'(1)) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_phit_injector.sv
// tb_phit_injector: directed-vector bench for phit_injector with hand-computed phit trains.
module tb_phit_injector;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] phit;
    logic        busy, err;
    logic [15:0] sent;
    int          checks = 0;
    int          errors = 0;
    int          exp_sent = 0;

    always #5 clk = ~clk;

    phit_injector_if bus ();

    phit_injector dut (
        .i_clk     (clk),
        .i_rst     (rst_n),
        .bus       (bus.slave),
        .o_phit    (phit),
        .o_busy    (busy),
        .o_err     (err),
        .o_pkt_sent(sent)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic desc(input logic [5:0] route, input logic [4:0] len);
        bus.i_pkt_valid = 1'b1;
        bus.i_pkt_route = route;
        bus.i_pkt_len   = len;
        @(negedge clk);
        bus.i_pkt_valid = 1'b0;
        bus.i_pkt_route = ~route;
        bus.i_pkt_len   = 5'd0;
    endtask

    task automatic load_words(input int len, input logic [9:0] base, input int gaps);
        for (int i = 0; i < len; i++) begin
            if (i > 0) repeat (gaps) @(negedge clk);
            bus.i_word_valid = 1'b1;
            bus.i_word       = base + 10'(i);
            @(negedge clk);
            bus.i_word_valid = 1'b0;
            bus.i_word       = 10'h155;
        end
    endtask

    task automatic send_pkt(input logic [5:0] route, input int len, input logic [9:0] base, input int gaps);
        logic [9:0]  w;
        logic [17:0] exp;
        check("rdy_pre", bus.o_pkt_ready, 1);
        desc(route, 5'(len));
        check("busy_load", busy, 1);
        check("wrdy_load", bus.o_word_ready, 1);
        check("prdy_load", bus.o_pkt_ready, 0);
        load_words(len, base, gaps);
        check("lat0", phit, 0);
        @(negedge clk);
        check("lat1", phit, 0);
        for (int i = 0; i < len; i++) begin
            w   = base + 10'(i);
            exp = (i == 0) ? {2'b10, route, w} : (i == len - 1) ? {2'b01, 6'b0, w} : {2'b11, 6'b0, w};
            @(negedge clk);
            check($sformatf("phit%0d", i), phit, exp);
            check("prdy_send", bus.o_pkt_ready, 0);
        end
        exp_sent = (exp_sent + 1) & 16'hFFFF;
        @(negedge clk);
        check("gap_phit", phit, 0);
        check("prdy_post", bus.o_pkt_ready, 1);
        check("busy_post", busy, 0);
        check("sent", sent, exp_sent);
    endtask

    task automatic bad_len(input logic [4:0] len);
        desc(6'b111111, len);
        check("err_pulse", err, 1);
        check("err_wrdy", bus.o_word_ready, 0);
        check("err_prdy", bus.o_pkt_ready, 1);
        check("err_phit", phit, 0);
        @(negedge clk);
        check("err_clear", err, 0);
        check("err_wrdy2", bus.o_word_ready, 0);
        check("err_sent", sent, exp_sent);
    endtask

    initial begin
        bus.i_pkt_valid  = 1'b0;
        bus.i_pkt_route  = '0;
        bus.i_pkt_len    = '0;
        bus.i_word_valid = 1'b0;
        bus.i_word       = '0;
        #1;
        check("rst_phit", phit, 0);
        check("rst_prdy", bus.o_pkt_ready, 1);
        check("rst_wrdy", bus.o_word_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_sent", sent, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send_pkt(6'b100111, 3, 10'h001, 0);
        send_pkt(6'b100111, 3, 10'h001, 4);
        bad_len(5'd1);
        bad_len(5'd17);
        send_pkt(6'b100111, 16, 10'h3F0, 0);

        // Abandon a packet during its second phit with an asynchronous reset.
        desc(6'b001101, 5'd3);
        load_words(3, 10'h055, 0);
        @(negedge clk);
        @(negedge clk);
        check("mid_head", phit, {2'b10, 6'b001101, 10'h055});
        @(negedge clk);
        check("mid_body", phit, {2'b11, 6'b0, 10'h056});
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_phit", phit, 0);
        check("mid_rst_prdy", bus.o_pkt_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sent", sent, 0);
        exp_sent = 0;
        @(negedge clk);
        check("mid_no_tail", phit, 0);
        rst_n = 1'b1;
        send_pkt(6'b010010, 2, 10'h2A0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
